// File: rtl/mem_pkg.sv
// mem_pkg: access-size encodings, exception codes and FSM state type for the memory-access stage.
package mem_pkg;
    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;
    localparam logic [3:0] EXC_NONE = 4'd0;
    localparam logic [3:0] EXC_ADEL = 4'd4;
    localparam logic [3:0] EXC_ADES = 4'd5;
    typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} mem_state_t;
endpackage

// File: rtl/load_align.sv
// load_align: picks the addressed byte/half of a little-endian read word and sign- or zero-extends it.
// Ports: rdata raw bus word, addr low address bits, MemReadType {zext, size}, result extended value.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  MemReadType,
    output logic [31:0] result
);
    logic [7:0]  b;
    logic [15:0] h;
    logic        sign;
    always_comb begin
        b      = rdata[{addr, 3'b000} +: 8];
        h      = addr[1] ? rdata[31:16] : rdata[15:0];
        sign   = !MemReadType[2] && (MemReadType[1:0] == SZ_BYTE ? b[7] : h[15]);
        result = MemReadType[1:0] == SZ_BYTE ? {{24{sign}}, b}
               : MemReadType[1:0] == SZ_HALF ? {{16{sign}}, h}
               : rdata;
    end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: load/store stage driving an SRAM-like request/handshake bus, with alignment and address-error traps.
// Optional feature macro MEM_UNALIGNED_TRAP_EN: defined -> misaligned half/word raise AdEL/AdES;
// undefined -> the low address bits are masked and the access proceeds.
// Ports: clk, rst (asynchronous, active low); MemRead/MemWrite/MemReadType/ALUResult/MemData/exception_i
// from execute; flush/hold pipeline control; data_* bus master side; ReadData/exception/BadVAddr/stall results.
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        MemReadType,
    input  logic [ADDR_W-1:0] ALUResult,
    input  logic [DATA_W-1:0] MemData,
    input  logic [3:0]        exception_i,
    input  logic              flush,
    input  logic              hold,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata,
    output logic [DATA_W-1:0] ReadData,
    output logic [3:0]        exception,
    output logic [ADDR_W-1:0] BadVAddr,
    output logic              stall
);
    mem_state_t        state_q, state_d;
    logic              wr_q;
    logic [1:0]        size_q;
    logic [2:0]        type_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic [1:0]        size;
    logic              addr_err, valid, idle;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata, aligned;

    assign size = MemReadType[1:0];
`ifdef MEM_UNALIGNED_TRAP_EN
    assign addr_err = (MemRead | MemWrite) &
                      ((size == SZ_HALF && ALUResult[0]) || (size == SZ_WORD && ALUResult[1:0] != 2'b00));
    assign addr     = ALUResult;
`else
    assign addr_err = 1'b0;
    assign addr     = {ALUResult[ADDR_W-1:2],
                       size == SZ_WORD ? 2'b00 : {ALUResult[1], ALUResult[0] & (size != SZ_HALF)}};
`endif
    assign valid     = (MemRead | MemWrite) && exception_i == EXC_NONE && !addr_err && !flush;
    assign wdata     = size == SZ_BYTE ? {4{MemData[7:0]}} : size == SZ_HALF ? {2{MemData[15:0]}} : MemData;
    assign exception = exception_i != EXC_NONE ? exception_i
                     : addr_err ? (MemRead ? EXC_ADEL : EXC_ADES) : EXC_NONE;
    assign BadVAddr  = (exception_i == EXC_NONE && addr_err) ? ALUResult : '0;

    // Bus follows the stage inputs while idle; once a request is pending the captured copy is held.
    assign idle       = state_q == IDLE;
    assign data_req   = idle ? valid : state_q == REQ;
    assign data_wr    = idle ? MemWrite : wr_q;
    assign data_size  = idle ? size : size_q;
    assign data_addr  = idle ? addr : addr_q;
    assign data_wdata = idle ? wdata : wdata_q;
    assign ReadData   = rdata_q;
    assign stall      = (idle && valid) || state_q == REQ || state_q == WAIT ||
                        (state_q == DRAIN && (MemRead || MemWrite));

    load_align u_align (
        .rdata       (data_rdata),
        .addr        (addr_q[1:0]),
        .MemReadType (type_q),
        .result      (aligned)
    );

    // A flush after acceptance must still consume the response, hence DRAIN instead of IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = !valid ? IDLE : data_addr_ok ? WAIT : REQ;
            REQ:     state_d = data_addr_ok ? (flush ? DRAIN : WAIT) : flush ? IDLE : REQ;
            WAIT:    state_d = data_data_ok ? (flush ? IDLE : DONE) : flush ? DRAIN : WAIT;
            DONE:    state_d = hold ? DONE : IDLE;
            DRAIN:   state_d = data_data_ok ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            type_q  <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                wr_q    <= MemWrite;
                size_q  <= size;
                type_q  <= MemReadType;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (state_q == WAIT && data_data_ok && !flush) rdata_q <= aligned;
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: randomized and directed checks of mem_access_stage against a behavioural model.
module tb_mem_access_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        MemRead, MemWrite, flush, hold;
    logic [2:0]  MemReadType;
    logic [31:0] ALUResult, MemData;
    logic [3:0]  exception_i;
    logic        data_req, data_wr, data_addr_ok, data_data_ok, stall;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata, ReadData, BadVAddr;
    logic [3:0]  exception;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_rd = '0;
`ifdef MEM_UNALIGNED_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    mem_access_stage dut (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .MemReadType(MemReadType),
        .ALUResult(ALUResult), .MemData(MemData), .exception_i(exception_i), .flush(flush), .hold(hold),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata), .ReadData(ReadData), .exception(exception), .BadVAddr(BadVAddr),
        .stall(stall)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [1:0] sz);
        return sz == 2'b00 ? 1 : sz == 2'b01 ? 2 : 4;
    endfunction

    function automatic logic [31:0] m_addr(input logic [31:0] a, input logic [1:0] sz);
        return TRAP ? a : a - (a % 32'(nbytes(sz)));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] d, input logic [1:0] sz);
        return sz == 2'b00 ? d[7:0] * 32'h01010101 : sz == 2'b01 ? d[15:0] * 32'h00010001 : d;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [31:0] a, input logic [2:0] t);
        int          n;
        logic [31:0] v, m;
        n = nbytes(t[1:0]) * 8;
        if (n == 32) return w;
        m = (32'd1 << n) - 32'd1;
        v = (w >> ((a % 32'd4) * 32'd8)) & m;
        if (!t[2] && v >= (32'd1 << (n - 1))) v = v | ~m;
        return v;
    endfunction

    // ---------------- drivers ----------------
    task automatic set_op(input logic rd, input logic wr, input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
        MemRead = rd; MemWrite = wr; MemReadType = t; ALUResult = a; MemData = d;
        exception_i = 4'd0; flush = 1'b0;
    endtask

    task automatic clear_op();
        set_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    endtask

    // Drives one full access from posedge+1 of its first cycle through its DONE cycle, acting as the slave.
    // addr_ok comes alat cycles late, data_ok dlat cycles after acceptance; noise adds spurious data_ok
    // while the request is not yet accepted.
    task automatic run_access(input int alat, input int dlat, input logic [31:0] rd, input bit noise,
                              output logic [31:0] a0, output logic [31:0] w0, output logic [2:0] ctl0,
                              output bit stable, output int scnt, output logic done_stall,
                              output logic [31:0] done_rd);
        int last;
        last = alat + 1 + dlat;
        stable = 1'b1;
        scnt = 0;
        a0 = '0; w0 = '0; ctl0 = '0;
        for (int c = 0; c <= last; c++) begin
            data_addr_ok = (c == alat);
            data_data_ok = (c == last) || (noise && c <= alat && $urandom_range(0, 1) == 1);
            data_rdata   = (c == last) ? rd : $urandom;
            @(negedge clk);
            scnt += int'(stall);
            if (c == 0) begin a0 = data_addr; w0 = data_wdata; ctl0 = {data_wr, data_size}; end
            if (c <= alat && (data_req !== 1'b1 || data_addr !== a0 || data_wdata !== w0 || {data_wr, data_size} !== ctl0)) stable = 1'b0;
            if (c > alat && data_req !== 1'b0) stable = 1'b0;
            @(posedge clk); #1;
        end
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        @(negedge clk);
        done_stall = stall;
        done_rd = ReadData;
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if ({data_req, data_wr, data_size} !== 4'h0) begin n_err++; $display("FAIL reset_bus_ctl got=%b exp=0000", {data_req, data_wr, data_size}); end
        n_cmp++; if ({data_addr, data_wdata} !== 64'h0) begin n_err++; $display("FAIL reset_bus_data got=%h exp=0", {data_addr, data_wdata}); end
        n_cmp++; if (ReadData !== 32'h0) begin n_err++; $display("FAIL reset_readdata got=%h exp=0", ReadData); end
        n_cmp++; if ({exception, BadVAddr, stall} !== 37'h0) begin n_err++; $display("FAIL reset_exc_stall got=%h exp=0", {exception, BadVAddr, stall}); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_best_case();
        logic [31:0] a0, w0, drd; logic [2:0] ctl; bit st; int sc; logic ds;
        set_op(1'b1, 1'b0, 3'b010, 32'h1000, 32'h0);
        run_access(0, 0, 32'h8899AABB, 1'b0, a0, w0, ctl, st, sc, ds, drd);
        exp_rd = 32'h8899AABB;
        n_cmp++; if (a0 !== 32'h1000) begin n_err++; $display("FAIL best_addr got=%h exp=%h", a0, 32'h1000); end
        n_cmp++; if (ctl !== 3'b010) begin n_err++; $display("FAIL best_wr_size got=%b exp=010", ctl); end
        n_cmp++; if (st !== 1'b1) begin n_err++; $display("FAIL best_req_stable got=%0d exp=1", st); end
        n_cmp++; if (sc !== 2) begin n_err++; $display("FAIL best_stall_cycles got=%0d exp=2", sc); end
        n_cmp++; if (ds !== 1'b0) begin n_err++; $display("FAIL best_done_stall got=%b exp=0", ds); end
        n_cmp++; if (drd !== exp_rd) begin n_err++; $display("FAIL best_readdata got=%h exp=%h", drd, exp_rd); end
        clear_op();
    endtask

    task automatic test_store_delayed();
        logic [31:0] a0, w0, drd; logic [2:0] ctl; bit st; int sc; logic ds; int dl;
        dl = $urandom_range(0, 2);
        set_op(1'b0, 1'b1, 3'b000, 32'h2001, 32'h000000A5);
        run_access(3, dl, $urandom, 1'b1, a0, w0, ctl, st, sc, ds, drd);
        n_cmp++; if (w0 !== 32'hA5A5A5A5) begin n_err++; $display("FAIL sb_wdata got=%h exp=A5A5A5A5", w0); end
        n_cmp++; if (ctl !== 3'b100) begin n_err++; $display("FAIL sb_wr_size got=%b exp=100", ctl); end
        n_cmp++; if (a0 !== 32'h2001) begin n_err++; $display("FAIL sb_addr got=%h exp=00002001", a0); end
        n_cmp++; if (st !== 1'b1) begin n_err++; $display("FAIL sb_req_stable got=%0d exp=1", st); end
        n_cmp++; if (sc !== 5 + dl) begin n_err++; $display("FAIL sb_stall_cycles got=%0d exp=%0d", sc, 5 + dl); end
        n_cmp++; if (ds !== 1'b0) begin n_err++; $display("FAIL sb_done_stall got=%b exp=0", ds); end
        clear_op();
    endtask

    task automatic test_misaligned();
`ifdef MEM_UNALIGNED_TRAP_EN
        set_op(1'b1, 1'b0, 3'b010, 32'h1002, 32'h0);
        @(negedge clk);
        n_cmp++; if (exception !== 4'd4) begin n_err++; $display("FAIL adel_code got=%0d exp=4", exception); end
        n_cmp++; if (BadVAddr !== 32'h1002) begin n_err++; $display("FAIL adel_badvaddr got=%h exp=00001002", BadVAddr); end
        n_cmp++; if ({data_req, stall} !== 2'b00) begin n_err++; $display("FAIL adel_req_stall got=%b exp=00", {data_req, stall}); end
        @(posedge clk); #1;
        set_op(1'b0, 1'b1, 3'b001, 32'h3001, 32'h1234BEEF);
        @(negedge clk);
        n_cmp++; if (exception !== 4'd5) begin n_err++; $display("FAIL ades_code got=%0d exp=5", exception); end
        n_cmp++; if (BadVAddr !== 32'h3001) begin n_err++; $display("FAIL ades_badvaddr got=%h exp=00003001", BadVAddr); end
        n_cmp++; if ({data_req, stall} !== 2'b00) begin n_err++; $display("FAIL ades_req_stall got=%b exp=00", {data_req, stall}); end
        @(posedge clk); #1;
`else
        logic [31:0] a0, w0, drd, rd; logic [2:0] ctl; bit st; int sc; logic ds;
        rd = $urandom;
        set_op(1'b1, 1'b0, 3'b010, 32'h1002, 32'h0);
        #1;
        n_cmp++; if ({exception, BadVAddr} !== 36'h0) begin n_err++; $display("FAIL noTrap_lw_exc got=%h exp=0", {exception, BadVAddr}); end
        run_access(0, 1, rd, 1'b0, a0, w0, ctl, st, sc, ds, drd);
        n_cmp++; if (a0 !== 32'h1000) begin n_err++; $display("FAIL noTrap_lw_addr got=%h exp=00001000", a0); end
        n_cmp++; if (drd !== m_load(rd, m_addr(32'h1002, 2'b10), 3'b010)) begin n_err++; $display("FAIL noTrap_lw_data got=%h exp=%h", drd, rd); end
        set_op(1'b0, 1'b1, 3'b001, 32'h3001, 32'h1234BEEF);
        #1;
        n_cmp++; if ({exception, BadVAddr} !== 36'h0) begin n_err++; $display("FAIL noTrap_sh_exc got=%h exp=0", {exception, BadVAddr}); end
        run_access(1, 0, $urandom, 1'b0, a0, w0, ctl, st, sc, ds, drd);
        n_cmp++; if (a0 !== 32'h3000) begin n_err++; $display("FAIL noTrap_sh_addr got=%h exp=00003000", a0); end
        n_cmp++; if (w0 !== 32'hBEEFBEEF) begin n_err++; $display("FAIL noTrap_sh_wdata got=%h exp=BEEFBEEF", w0); end
        n_cmp++; if (st !== 1'b1) begin n_err++; $display("FAIL noTrap_sh_stable got=%0d exp=1", st); end
`endif
        clear_op();
    endtask

    task automatic test_exc_passthrough();
        logic [3:0] e;
        e = 4'($urandom_range(1, 15));
        set_op(1'b1, 1'b0, 3'b010, 32'h0000_4440, 32'h0);
        exception_i = e;
        @(negedge clk);
        n_cmp++; if (exception !== e) begin n_err++; $display("FAIL exc_pass_code got=%0d exp=%0d", exception, e); end
        n_cmp++; if ({data_req, stall} !== 2'b00) begin n_err++; $display("FAIL exc_pass_req_stall got=%b exp=00", {data_req, stall}); end
        @(posedge clk); #1;
        exception_i = 4'd0;
        flush = 1'b1;
        @(negedge clk);
        n_cmp++; if ({data_req, stall} !== 2'b00) begin n_err++; $display("FAIL flush_idle_req_stall got=%b exp=00", {data_req, stall}); end
        @(posedge clk); #1;
        clear_op();
    endtask

    task automatic test_loads();
        logic [31:0] a0, w0, drd, a, rd, ev; logic [2:0] ctl, t; bit st; int sc; logic ds;
        for (int i = 0; i < 3; i++) begin
            a  = i == 2 ? 32'h1002 : 32'h1003;
            t  = i == 0 ? 3'b000 : i == 1 ? 3'b100 : 3'b001;
            ev = i == 0 ? 32'hFFFFFF80 : i == 1 ? 32'h00000080 : 32'hFFFF8011;
            set_op(1'b1, 1'b0, t, a, 32'h0);
            run_access(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 32'h80112233, 1'b1, a0, w0, ctl, st, sc, ds, drd);
            exp_rd = ev;
            n_cmp++; if (drd !== ev) begin n_err++; $display("FAIL load_dir%0d got=%h exp=%h", i, drd, ev); end
        end
        for (int i = 0; i < 12; i++) begin
            t  = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))};
            a  = $urandom & ~(32'(nbytes(t[1:0])) - 32'd1);
            rd = $urandom;
            set_op(1'b1, 1'b0, t, a, $urandom);
            run_access(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), rd, 1'b1, a0, w0, ctl, st, sc, ds, drd);
            exp_rd = m_load(rd, a, t);
            n_cmp++; if (drd !== exp_rd) begin n_err++; $display("FAIL load_rand%0d type=%b addr=%h got=%h exp=%h", i, t, a, drd, exp_rd); end
        end
        clear_op();
    endtask

    task automatic test_flush_drain();
        logic [31:0] a0, w0, drd; logic [2:0] ctl; bit st; int sc; logic ds;
        set_op(1'b1, 1'b0, 3'b010, 32'h4000, 32'h0);
        data_addr_ok = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        data_addr_ok = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL flush_wait_stall got=%b exp=1", stall); end
        @(posedge clk); #1;
        set_op(1'b1, 1'b0, 3'b010, 32'h5000, 32'h0);
        for (int k = 0; k < 2; k++) begin
            data_data_ok = (k == 1);
            data_rdata   = k == 1 ? 32'hDEADBEEF : $urandom;
            @(negedge clk);
            n_cmp++; if ({data_req, stall} !== 2'b01) begin n_err++; $display("FAIL drain%0d_req_stall got=%b exp=01", k, {data_req, stall}); end
            n_cmp++; if (ReadData !== exp_rd) begin n_err++; $display("FAIL drain%0d_readdata got=%h exp=%h", k, ReadData, exp_rd); end
            @(posedge clk); #1;
        end
        data_data_ok = 1'b0;
        run_access(0, 0, 32'h13572468, 1'b0, a0, w0, ctl, st, sc, ds, drd);
        n_cmp++; if (a0 !== 32'h5000) begin n_err++; $display("FAIL post_drain_addr got=%h exp=00005000", a0); end
        n_cmp++; if (st !== 1'b1) begin n_err++; $display("FAIL post_drain_req got=%0d exp=1", st); end
        n_cmp++; if (drd !== 32'h13572468) begin n_err++; $display("FAIL post_drain_data got=%h exp=13572468", drd); end
        exp_rd = 32'h13572468;
        set_op(1'b1, 1'b0, 3'b010, 32'h6000, 32'h0);
        @(negedge clk);
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        n_cmp++; if ({data_req, stall} !== 2'b11) begin n_err++; $display("FAIL flush_req_state got=%b exp=11", {data_req, stall}); end
        @(posedge clk); #1;
        clear_op();
        @(negedge clk);
        n_cmp++; if ({data_req, stall} !== 2'b00) begin n_err++; $display("FAIL flush_req_idle got=%b exp=00", {data_req, stall}); end
        n_cmp++; if (ReadData !== exp_rd) begin n_err++; $display("FAIL flush_req_readdata got=%h exp=%h", ReadData, exp_rd); end
        @(posedge clk); #1;
    endtask

    task automatic test_hold();
        logic [31:0] a0, w0, drd, rd; logic [2:0] ctl; bit st; int sc; logic ds;
        rd = $urandom;
        set_op(1'b1, 1'b0, 3'b010, 32'h7004, 32'h0);
        hold = 1'b1;
        run_access(1, 1, rd, 1'b0, a0, w0, ctl, st, sc, ds, drd);
        exp_rd = rd;
        n_cmp++; if (drd !== rd) begin n_err++; $display("FAIL hold_data got=%h exp=%h", drd, rd); end
        for (int k = 0; k < 2; k++) begin
            data_rdata = $urandom;
            data_data_ok = 1'b1;
            @(negedge clk);
            n_cmp++; if ({ReadData, data_req, stall} !== {rd, 2'b00}) begin n_err++; $display("FAIL hold%0d got=%h/%b exp=%h/00", k, ReadData, {data_req, stall}, rd); end
            @(posedge clk); #1;
        end
        data_data_ok = 1'b0;
        hold = 1'b0;
        @(negedge clk);
        n_cmp++; if (ReadData !== rd) begin n_err++; $display("FAIL hold_release got=%h exp=%h", ReadData, rd); end
        @(posedge clk); #1;
        set_op(1'b0, 1'b1, 3'b010, 32'h7100, 32'h0BADF00D);
        run_access(0, 0, $urandom, 1'b0, a0, w0, ctl, st, sc, ds, drd);
        n_cmp++; if (a0 !== 32'h7100 || st !== 1'b1) begin n_err++; $display("FAIL after_hold_req got=%h/%0d exp=00007100/1", a0, st); end
        clear_op();
    endtask

    task automatic test_reset_mid();
        set_op(1'b1, 1'b0, 3'b010, 32'h8000, 32'h0);
        data_addr_ok = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        data_addr_ok = 1'b0;
        @(negedge clk);
        n_cmp++; if (data_req !== 1'b0) begin n_err++; $display("FAIL rst_mid_wait_req got=%b exp=0", data_req); end
        #1 rst = 1'b0;
        #1;
        n_cmp++; if ({data_req, stall} !== 2'b11) begin n_err++; $display("FAIL rst_mid_idle got=%b exp=11", {data_req, stall}); end
        n_cmp++; if (ReadData !== 32'h0) begin n_err++; $display("FAIL rst_mid_readdata got=%h exp=0", ReadData); end
        exp_rd = 32'h0;
        clear_op();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [31:0] a0, w0, drd, a, d, rd, ea; logic [2:0] ctl, t; bit st; int sc; logic ds, wr; int al, dl;
        for (int i = 0; i < 30; i++) begin
            wr = 1'($urandom_range(0, 1));
            t  = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))};
            a  = (!TRAP && $urandom_range(0, 3) == 0) ? $urandom : ($urandom & ~(32'(nbytes(t[1:0])) - 32'd1));
            d  = $urandom;
            rd = $urandom;
            al = int'($urandom_range(0, 3));
            dl = int'($urandom_range(0, 3));
            ea = m_addr(a, t[1:0]);
            set_op(!wr, wr, t, a, d);
            run_access(al, dl, rd, 1'b1, a0, w0, ctl, st, sc, ds, drd);
            n_cmp++; if (a0 !== ea) begin n_err++; $display("FAIL rnd%0d_addr got=%h exp=%h", i, a0, ea); end
            n_cmp++; if (w0 !== m_wdata(d, t[1:0])) begin n_err++; $display("FAIL rnd%0d_wdata got=%h exp=%h", i, w0, m_wdata(d, t[1:0])); end
            n_cmp++; if (ctl !== {wr, t[1:0]}) begin n_err++; $display("FAIL rnd%0d_ctl got=%b exp=%b", i, ctl, {wr, t[1:0]}); end
            n_cmp++; if (st !== 1'b1) begin n_err++; $display("FAIL rnd%0d_req_stable got=%0d exp=1", i, st); end
            n_cmp++; if (sc !== al + 2 + dl) begin n_err++; $display("FAIL rnd%0d_stall_cycles got=%0d exp=%0d", i, sc, al + 2 + dl); end
            n_cmp++; if (ds !== 1'b0) begin n_err++; $display("FAIL rnd%0d_done_stall got=%b exp=0", i, ds); end
            if (!wr) begin
                exp_rd = m_load(rd, ea, t);
                n_cmp++; if (drd !== exp_rd) begin n_err++; $display("FAIL rnd%0d_load got=%h exp=%h", i, drd, exp_rd); end
            end
        end
        clear_op();
    endtask

    initial begin
        clear_op();
        hold = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata = 32'h0;
        test_reset();
        test_best_case();
        test_store_delayed();
        test_misaligned();
        test_exc_passthrough();
        test_loads();
        test_flush_drain();
        test_hold();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage directly downstream of the execute stage. It consumes the execute stage's ALU result (address), store data and memory controls, then drives the SRAM-like data bus with a request/handshake FSM. It returns aligned, extended load data and stalls the pipeline while an access is outstanding. It also detects misaligned addresses and raises address-error exceptions.

## Interface
Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; only 32 is supported.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- MemRead  in  1  load in this stage.
- MemWrite  in  1  store in this stage.
- MemReadType  in  3  access type; bit 2 = zero-extend, bits [1:0] = size (00 byte, 01 half, 10 word).
- ALUResult  in  32  effective address.
- MemData  in  32  store data, already forwarded.
- exception_i  in  4  upstream exception code; 0 = none.
- flush  in  1  kill the current instruction.
- hold  in  1  downstream not ready; keep the result.
- data_req  out  1  bus request.
- data_wr  out  1  1 = write.
- data_size  out  2  equals MemReadType[1:0].
- data_addr  out  32  bus address.
- data_wdata  out  32  replicated store data.
- data_addr_ok  in  1  request accepted.
- data_data_ok  in  1  response valid.
- data_rdata  in  32  raw read word.
- ReadData  out  32  aligned and extended load result.
- exception  out  4  resulting exception code.
- BadVAddr  out  32  faulting address.
- stall  out  1  freeze upstream stages.

## Operation
- An access is valid when (MemRead|MemWrite) & exception_i==0 & !addr_err & !flush.
- Address errors:
  - addr_err: half with addr[0]!=0, or word with addr[1:0]!=0.
  - A load with addr_err gives exception=4 (AdEL).
  - A store with addr_err gives exception=5 (AdES).
  - In both cases BadVAddr=ALUResult. No request is issued and stall stays low.
- exception_i!=0 passes through unchanged and suppresses the access.
- data_addr is the full byte address; the slave uses data_size.
- Store data: byte gives {4{MemData[7:0]}}, half gives {2{MemData[15:0]}}, word gives MemData.
- Load data: select byte/half by addr[1:0] (little-endian), then sign-extend, or zero-extend when MemReadType[2]=1.
- FSM states IDLE, REQ, WAIT, DONE, DRAIN:
  - IDLE: data_req=valid. If data_addr_ok, go to WAIT; otherwise, if valid, go to REQ.
  - REQ: data_req=1 and the bus outputs are held. data_addr_ok goes to WAIT. flush goes to IDLE, with no request outstanding.
  - WAIT: on data_data_ok, capture the aligned data and go to DONE. flush goes to DRAIN.
  - DONE: ReadData comes from the register. If hold, stay in DONE; otherwise go to IDLE.
  - DRAIN: data_req=0. Discard the data on data_data_ok, then go to IDLE. Flush never abandons an accepted request.
- stall = (IDLE & valid) | REQ | WAIT | (DRAIN & (MemRead|MemWrite)).

## Timing
- Reset values:
  - state=IDLE.
  - data_req=0, data_wr=0, data_size=0, data_addr=0, data_wdata=0.
  - ReadData=0, exception=0, BadVAddr=0, stall=0.
- Bus outputs are combinational from the stage inputs in IDLE, and registered copies in REQ.
- Best case (addr_ok in cycle 0, data_ok in cycle 1): stall is high in cycles 0 and 1; DONE is in cycle 2 with stall low.
- data_addr_ok and data_data_ok in the same cycle: the data is taken only in WAIT. A data_ok seen in IDLE or REQ is ignored.
- Stores also wait for data_data_ok, which acts as the write acknowledge.
- Reset mid-transaction returns to IDLE at once; the bus slave is reset by the same rst.

## Configuration
- Macro MEM_UNALIGNED_TRAP_EN:
  - Defined: misaligned accesses raise AdEL/AdES as above.
  - Undefined: addr_err is forced to 0 and data_addr[1:0] is masked to zero for half/word accesses (half masks bit 0, word masks bits [1:0]). The access proceeds and BadVAddr stays 0.

## Structure
- Package mem_pkg holds:
  - size constants SZ_BYTE, SZ_HALF, SZ_WORD.
  - EXC_NONE=0, EXC_ADEL=4, EXC_ADES=5.
  - the state enum mem_state_t.
- Sub-module load_align: combinational extraction and extension (inputs rdata, addr[1:0], MemReadType; output 32-bit result).

## Test plan
- LW addr 0x1000, addr_ok in cycle 0, data_ok in cycle 1 with rdata 0x8899AABB -> ReadData=0x8899AABB in cycle 2, stall high for exactly 2 cycles.
- LB addr 0x1003, rdata 0x80112233 -> 0xFFFFFF80; LBU -> 0x00000080; LH addr 0x1002 -> 0xFFFF8011.
- SB addr 0x2001, data 0x000000A5 -> data_wdata=0xA5A5A5A5, data_size=00, data_wr=1; addr_ok delayed 3 cycles -> data_req held stable throughout.
- LW addr 0x1002 with macro defined -> exception=4, BadVAddr=0x1002, no data_req, stall=0; SH addr 0x3001 -> exception=5.
- flush in WAIT, data_ok 2 cycles later, new LW pending -> DRAIN discards the old data, the new request is issued only after the drain, and ReadData never shows the flushed data.
- hold=1 for 3 cycles in DONE -> state stays DONE and ReadData is stable.
